// File: rtl/mem_req_arbiter_pkg.sv
// rtl/mem_req_arbiter_pkg.sv - shared constants, lock-state enum and width helper for the memory request arbiter
package mem_req_arbiter_pkg;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    typedef enum logic [1:0] {
        LOCK_IDLE   = 2'd0,
        LOCK_HOLD_I = 2'd1,
        LOCK_HOLD_D = 2'd2
    } lock_state_e;

    function automatic int ot_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// rtl/mem_req_arbiter_if.sv - inst/data/memory sram-like handshake bundle seen by the arbiter
interface mem_req_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;

    logic              data_req;
    logic [3:0]        data_wstrb;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    logic              mem_req;
    logic [3:0]        mem_wstrb;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_addr_ok;
    logic              mem_data_ok;
    logic [DATA_W-1:0] mem_rdata;

    modport arb (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wstrb, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_req, mem_wstrb, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport env (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_req, mem_wstrb, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );
endinterface

// File: rtl/mem_req_arbiter_order_fifo.sv
// rtl/mem_req_arbiter_order_fifo.sv - 1-bit in-order source FIFO tracking outstanding requests
module arb_order_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_i,
    input  logic                 din_i,
    input  logic                 pop_i,
    output logic                 dout_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
        count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
endmodule

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - shares one sram-like memory port between instruction fetch and data access
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int OT_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    mem_req_arbiter_if.arb                  bus,
    output logic [ot_cnt_w(OT_DEPTH)-1:0]   ot_count
);
    lock_state_e       state_q, state_d;
    logic              grant;
    logic              granted_req;
    logic              req_out;
    logic              accept;
    logic              fifo_full, fifo_empty, fifo_head, pop;
    logic [ot_cnt_w(OT_DEPTH)-1:0] fifo_count;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] wdata_mux;

    // A held lock pins the grant so the stalled request stays stable until accepted.
    always_comb begin
        grant = SRC_INST;
        case (state_q)
            LOCK_HOLD_I: grant = SRC_INST;
            LOCK_HOLD_D: grant = SRC_DATA;
            default:     grant = bus.data_req ? SRC_DATA : SRC_INST;
        endcase
    end

    assign granted_req = (grant == SRC_DATA) ? bus.data_req : bus.inst_req;
    assign req_out     = granted_req & ~fifo_full & ~reset;
    assign accept      = req_out & bus.mem_addr_ok;
    assign pop         = bus.mem_data_ok & ~fifo_empty & ~reset;

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOCK_IDLE: begin
                if (req_out && !bus.mem_addr_ok)
                    state_d = (grant == SRC_DATA) ? LOCK_HOLD_D : LOCK_HOLD_I;
            end
            LOCK_HOLD_I, LOCK_HOLD_D: begin
                if (accept) state_d = LOCK_IDLE;
            end
            default: state_d = LOCK_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= LOCK_IDLE;
        else       state_q <= state_d;
    end

    arb_order_fifo #(.DEPTH(OT_DEPTH)) u_order_fifo (
        .clk     (clk),
        .rst     (reset),
        .push_i  (accept),
        .din_i   (grant),
        .pop_i   (pop),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign addr_mux  = (grant == SRC_DATA) ? bus.data_addr : bus.inst_addr;
    assign wdata_mux = (grant == SRC_DATA) ? bus.data_wdata : '0;

    assign bus.mem_req      = req_out;
    assign bus.mem_addr     = reset ? '0 : addr_mux;
    assign bus.mem_wdata    = reset ? '0 : wdata_mux;
    assign bus.mem_wstrb    = (!reset && grant == SRC_DATA) ? bus.data_wstrb : 4'h0;
    assign bus.inst_addr_ok = accept & (grant == SRC_INST);
    assign bus.data_addr_ok = accept & (grant == SRC_DATA);
    assign bus.inst_data_ok = pop & (fifo_head == SRC_INST);
    assign bus.data_data_ok = pop & (fifo_head == SRC_DATA);
    assign bus.inst_rdata   = reset ? '0 : bus.mem_rdata;
    assign bus.data_rdata   = reset ? '0 : bus.mem_rdata;
    assign ot_count         = reset ? '0 : fifo_count;
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - self-checking bench for mem_req_arbiter against a queue-based reference model
module tb_mem_req_arbiter;
    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] ot_count;
    int         checks = 0;
    int         errors = 0;

    mem_req_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_req_arbiter #(.ADDR_W(32), .DATA_W(32), .OT_DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .ot_count (ot_count)
    );

    always #5 clk = ~clk;

    // Reference model: owner of a stalled request (0 none, 1 inst, 2 data) and the response order queue.
    int  m_lock = 0;
    bit  m_q[$];
    bit  s_g, s_req, s_acc, s_pop;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        bit        g, req, full, acc, popv, head;
        logic [31:0] e_addr, e_wdata, rd;
        logic [3:0]  e_wstrb;
        #4;
        if (m_lock == 1)      g = 1'b0;
        else if (m_lock == 2) g = 1'b1;
        else                  g = bus.data_req;
        full  = (m_q.size() == 4);
        req   = (g ? bus.data_req : bus.inst_req) && !full && !reset;
        acc   = req && bus.mem_addr_ok;
        popv  = bus.mem_data_ok && (m_q.size() > 0) && !reset;
        head  = (m_q.size() > 0) ? m_q[0] : 1'b0;
        e_addr  = reset ? 32'h0 : (g ? bus.data_addr : bus.inst_addr);
        e_wdata = (reset || !g) ? 32'h0 : bus.data_wdata;
        e_wstrb = (reset || !g) ? 4'h0 : bus.data_wstrb;
        rd      = reset ? 32'h0 : bus.mem_rdata;
        chk("mem_req",      bus.mem_req, req);
        chk("mem_addr",     bus.mem_addr, e_addr);
        chk("mem_wdata",    bus.mem_wdata, e_wdata);
        chk("mem_wstrb",    bus.mem_wstrb, e_wstrb);
        chk("inst_addr_ok", bus.inst_addr_ok, acc && !g);
        chk("data_addr_ok", bus.data_addr_ok, acc && g);
        chk("inst_data_ok", bus.inst_data_ok, popv && !head);
        chk("data_data_ok", bus.data_data_ok, popv && head);
        chk("inst_rdata",   bus.inst_rdata, rd);
        chk("data_rdata",   bus.data_rdata, rd);
        chk("ot_count",     ot_count, reset ? 0 : m_q.size());
        s_g = g; s_req = req; s_acc = acc; s_pop = popv;
    endtask

    task automatic advance();
        bit aok;
        aok = bus.mem_addr_ok;
        @(posedge clk);
        #1;
        if (!reset) begin
            if (s_pop) void'(m_q.pop_front());
            if (s_acc) m_q.push_back(s_g);
            if (m_lock == 0 && s_req && !aok) m_lock = s_g ? 2 : 1;
            else if (m_lock != 0 && s_acc)   m_lock = 0;
        end
    endtask

    task automatic drain();
        bus.inst_req = 1'b0; bus.data_req = 1'b0; bus.mem_data_ok = 1'b1;
        for (int k = 0; k < 10 && m_q.size() > 0; k++) begin
            bus.mem_rdata = $urandom;
            settle(); advance();
        end
        bus.mem_data_ok = 1'b0;
        settle();
        chk("drain_ot", ot_count, 0);
        advance();
    endtask

    initial begin
        reset = 1'b1;
        bus.inst_req = 1'b1; bus.inst_addr = 32'h1c000000;
        bus.data_req = 1'b1; bus.data_wstrb = 4'hF; bus.data_addr = 32'h8; bus.data_wdata = 32'h5;
        bus.mem_addr_ok = 1'b1; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'hdead;
        settle();
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_rdata", bus.inst_rdata, 0);
        advance();
        reset = 1'b0;
        bus.mem_data_ok = 1'b0; bus.data_wstrb = 4'h0;

        // Simultaneous requests: data wins, inst follows, responses return in order.
        settle();
        chk("t1_d_first", bus.data_addr_ok, 1);
        chk("t1_addr_d", bus.mem_addr, 32'h8);
        advance();
        bus.data_req = 1'b0;
        settle();
        chk("t1_i_next", bus.inst_addr_ok, 1);
        advance();
        bus.inst_req = 1'b0; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'hAA;
        settle();
        chk("t1_resp_d", bus.data_data_ok, 1);
        chk("t1_rdata_d", bus.data_rdata, 32'hAA);
        advance();
        bus.mem_rdata = 32'hBB;
        settle();
        chk("t1_resp_i", bus.inst_data_ok, 1);
        chk("t1_rdata_i", bus.inst_rdata, 32'hBB);
        advance();
        bus.mem_data_ok = 1'b0;

        // Stalled inst request holds the lock against a later data request.
        bus.inst_req = 1'b1; bus.inst_addr = 32'h1c000000; bus.mem_addr_ok = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle(); chk("t2_hold_addr", bus.mem_addr, 32'h1c000000); advance();
        end
        bus.data_req = 1'b1; bus.data_addr = 32'h20;
        settle(); chk("t2_locked", bus.mem_addr, 32'h1c000000); advance();
        bus.mem_addr_ok = 1'b1;
        settle(); chk("t2_i_acc", bus.inst_addr_ok, 1); advance();
        bus.inst_req = 1'b0;
        settle(); chk("t2_d_acc", bus.data_addr_ok, 1); advance();
        drain();

        // Fill to OT_DEPTH, then a single response frees one slot.
        bus.inst_req = 1'b1; bus.mem_addr_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            bus.inst_addr = 32'h100 + 32'(k * 4);
            settle(); advance();
        end
        bus.inst_addr = 32'h200; bus.mem_data_ok = 1'b1; bus.mem_rdata = 32'h55;
        settle();
        chk("t3_full_noreq", bus.mem_req, 0);
        chk("t3_full_ot", ot_count, 4);
        chk("t3_pop_i", bus.inst_data_ok, 1);
        advance();
        bus.mem_data_ok = 1'b0;
        settle();
        chk("t3_ot3", ot_count, 3);
        chk("t3_req_again", bus.mem_req, 1);
        advance();
        drain();

        // Data write fields pass through; its ack goes to the data side only.
        bus.data_req = 1'b1; bus.data_wstrb = 4'hF; bus.data_wdata = 32'h12345678; bus.data_addr = 32'h40;
        settle();
        chk("t4_wstrb", bus.mem_wstrb, 4'hF);
        chk("t4_wdata", bus.mem_wdata, 32'h12345678);
        advance();
        bus.data_req = 1'b0; bus.mem_data_ok = 1'b1;
        settle();
        chk("t4_ack_d", bus.data_data_ok, 1);
        chk("t4_ack_noti", bus.inst_data_ok, 0);
        advance();

        // Response with nothing outstanding is ignored.
        settle();
        chk("t5_no_i", bus.inst_data_ok, 0);
        chk("t5_no_d", bus.data_data_ok, 0);
        chk("t5_ot0", ot_count, 0);
        advance();
        bus.mem_data_ok = 1'b0;

        // Asynchronous reset with two outstanding.
        bus.inst_req = 1'b1;
        settle(); advance();
        settle(); advance();
        bus.inst_req = 1'b0;
        reset = 1'b1;
        #1;
        chk("t6_async_ot", ot_count, 0);
        chk("t6_async_req", bus.mem_req, 0);
        m_q.delete(); m_lock = 0;
        settle(); advance();
        reset = 1'b0; bus.mem_data_ok = 1'b1;
        settle();
        chk("t6_drop_i", bus.inst_data_ok, 0);
        chk("t6_drop_d", bus.data_data_ok, 0);
        advance();

        // Randomized traffic; a locked side keeps its request stable.
        for (int i = 0; i < 400; i++) begin
            if (m_lock != 1) begin
                bus.inst_req  = 1'($urandom_range(0, 1));
                bus.inst_addr = $urandom;
            end
            if (m_lock != 2) begin
                bus.data_req   = 1'($urandom_range(0, 1));
                bus.data_addr  = $urandom;
                bus.data_wstrb = 4'($urandom_range(0, 15));
                bus.data_wdata = $urandom;
            end
            bus.mem_addr_ok = 1'($urandom_range(0, 1));
            bus.mem_data_ok = ($urandom_range(0, 2) != 0);
            bus.mem_rdata   = $urandom;
            settle(); advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter
Overview:
Shares one SRAM-like memory port between instruction fetch (IF) and data access (EX/MEM), both using req/addr_ok/data_ok handshakes. Keeps an in-order FIFO of request sources so each response goes back to the requester that issued it. Sits between mycpu_top's inst/data sram ports and the single memory bridge.
Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
OT_DEPTH, 4, max outstanding accepted-but-unanswered requests (power of 2, >=2)
Ports:
clk  in  1  clock
reset  in  1  reset; asynchronous, active-high
inst_req  in  1  IF request valid
inst_addr  in  ADDR_W  IF address
inst_addr_ok  out  1  IF request accepted this cycle
inst_data_ok  out  1  IF response valid this cycle
inst_rdata  out  DATA_W  IF read data (mem_rdata passthrough)
data_req  in  1  data request valid
data_wstrb  in  4  byte strobes; nonzero means write
data_addr  in  ADDR_W  data address
data_wdata  in  DATA_W  write data
data_addr_ok  out  1  data request accepted this cycle
data_data_ok  out  1  data response valid (read data or write ack)
data_rdata  out  DATA_W  data read data (mem_rdata passthrough)
mem_req  out  1  downstream request valid
mem_wstrb  out  4  downstream strobes (IF grant drives 0)
mem_addr  out  ADDR_W  downstream address
mem_wdata  out  DATA_W  downstream write data (IF grant drives 0)
mem_addr_ok  in  1  downstream accepted request
mem_data_ok  in  1  downstream response, strictly in request order
mem_rdata  in  DATA_W  downstream read data
ot_count  out  $clog2(OT_DEPTH)+1  outstanding request count
Behaviour:
- Lock FSM with states IDLE, HOLD_I, HOLD_D. In IDLE, grant goes to data if data_req, else to inst if inst_req (data has priority).
- In HOLD_x, grant is forced to x whether or not the other side requests. The downstream request stays stable until accepted.
- Transitions: IDLE->HOLD_x when mem_req & ~mem_addr_ok with grant x; HOLD_x->IDLE on mem_addr_ok; IDLE stays on acceptance or no request.
- mem_req = granted req & ~fifo_full.
- Request fields are muxed combinationally from the granted side.
- x_addr_ok = mem_addr_ok & mem_req & grant==x. Zero cycles of added latency.
- On acceptance (mem_req & mem_addr_ok), the source bit (0=inst, 1=data) is pushed into the order FIFO.
- On mem_data_ok with FIFO non-empty, the head is popped. inst_data_ok or data_data_ok is asserted combinationally in the same cycle according to the head bit.
- inst_rdata and data_rdata always equal mem_rdata.
- FIFO full (ot_count==OT_DEPTH): mem_req held 0 even if a pop happens the same cycle (no bypass). Lock state is kept.
- Push and pop in the same cycle when not full: ot_count is unchanged and the pointers wrap modulo OT_DEPTH.
- mem_data_ok while the FIFO is empty: ignored; no data_ok is asserted and no state changes.
- Reset (async, any cycle): FSM goes to IDLE, pointers and ot_count go to 0. All outputs are driven 0 while reset is high.
- Responses still outstanding across a reset are dropped under the empty rule.
- A requester deasserting req while in HOLD is a protocol violation and is not handled.
Decomposition:
- Shared package: SRC_INST/SRC_DATA constants, lock-state enum, OT count width function.
- Sub-module arb_order_fifo: 1-bit synchronous FIFO, depth OT_DEPTH, with push/pop/full/empty/count.
Test Plan:
- Both sides request in the same cycle, addr 0x1c000000 (I) and 0x8 (D), mem_addr_ok=1 -> D accepted first, I accepted next cycle; responses 0xAA then 0xBB land on data_data_ok then inst_data_ok.
- inst_req with mem_addr_ok=0 for 3 cycles, then data_req rises -> mem_addr stays 0x1c000000 until accepted, then data is granted.
- 4 inst requests accepted with no responses -> ot_count=4, mem_req=0 with a 5th pending; one mem_data_ok -> inst_data_ok=1, ot_count=3, mem_req=1 next cycle.
- Data write with wstrb=0xF, wdata=0x12345678 -> mem_wstrb=0xF, mem_wdata=0x12345678; its ack asserts data_data_ok only.
- mem_data_ok with FIFO empty -> both data_ok stay 0, ot_count=0.
- Reset asserted with 2 outstanding -> ot_count=0 asynchronously; responses arriving later are ignored.
